// File: rtl/mouse_click_ctl.sv
// mouse_click_ctl: synchronises and debounces the raw left mouse button.
// Outputs are single-cycle press/release strobes, a clean held level, and
// the cursor position frozen at the moment a press is confirmed.
// Optional double-click detection is built when the macro DCLICK_EN is defined.
module mouse_click_ctl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DCLICK_WINDOW   = 32_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic        btn_held,
  output logic        press_pulse,
  output logic        release_pulse,
  output logic [11:0] click_xpos,
  output logic [11:0] click_ypos,
  output logic        dclick_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          s1, s2;
  logic [11:0]   x1, x2, y1, y2;
  logic          press_n, release_n;

  // Two-flop synchroniser; positions get the same delay so they line up with s2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      x1 <= '0;
      x2 <= '0;
      y1 <= '0;
      y2 <= '0;
    end else begin
      s1 <= mouse_left;
      s2 <= s1;
      x1 <= mouse_xpos;
      x2 <= x1;
      y1 <= mouse_ypos;
      y2 <= y1;
    end
  end

  // Next-state and debounce counter; the counter stops at CNT_LAST so it never wraps
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    case (state)
      IDLE: begin
        if (s2) begin
          state_n = PRESS_DB;
          cnt_n   = '0;
        end
      end
      PRESS_DB: begin
        if (!s2) begin
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_n = HELD;
          press_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s2) begin
          state_n = RELEASE_DB;
          cnt_n   = '0;
        end
      end
      RELEASE_DB: begin
        if (s2) begin
          state_n = HELD;
        end else if (cnt == CNT_LAST) begin
          state_n   = IDLE;
          release_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counter and registered outputs; coordinates load only on a confirmed press
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      btn_held      <= 1'b0;
      click_xpos    <= '0;
      click_ypos    <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      btn_held      <= (state_n == HELD) || (state_n == RELEASE_DB);
      if (press_n) begin
        click_xpos <= x2;
        click_ypos <= y2;
      end
    end
  end

`ifdef DCLICK_EN
  localparam int WW = $clog2(DCLICK_WINDOW) + 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(DCLICK_WINDOW - 1);

  logic [WW-1:0] win_cnt;
  logic          win_act;
  // Set by a double click so the release that follows does not reopen the
  // window; this keeps a triple click down to a single dclick_pulse.
  logic          skip_arm;

  // Double-click window: opened by a confirmed release, closed by timeout or by a press
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt      <= '0;
      win_act      <= 1'b0;
      skip_arm     <= 1'b0;
      dclick_pulse <= 1'b0;
    end else begin
      dclick_pulse <= 1'b0;
      if (press_n) begin
        dclick_pulse <= win_act;
        skip_arm     <= win_act;
        win_act      <= 1'b0;
      end else if (release_n) begin
        if (!skip_arm) begin
          win_act <= 1'b1;
          win_cnt <= '0;
        end
        skip_arm <= 1'b0;
      end else if (win_act) begin
        if (win_cnt == WIN_LAST) win_act <= 1'b0;
        else                     win_cnt <= win_cnt + 1'b1;
      end
    end
  end
`else
  assign dclick_pulse = 1'b0;
`endif

endmodule
